// File: rtl/fb_fade_engine.sv
// rtl/fb_fade_engine.sv - framebuffer fill / fade-down / copy pass engine
//
// Purpose: walks the framebuffer once per start and writes every pixel in
// address order: a constant fill colour, a per-channel saturating fade of the
// current framebuffer contents, or a copy from a source RAM. Addresses are only
// issued while blank_i is high. Each issued address yields exactly one write on
// the cycle after the address is presented.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        asynchronous active-low reset
//   start_i       request one pass (sampled in IDLE only)
//   mode_i        0 fill, 1 fade-down, 2 copy, 3 no-op
//   fill_color_i  {R,G,B} constant used by mode 0
//   blank_i       framebuffer write window open
//   rd_addr_o     framebuffer read address
//   rd_data_i     framebuffer read data, valid one cycle after rd_addr_o
//   src_addr_o    source RAM address (same value as rd_addr_o)
//   src_data_i    source RAM data, valid one cycle after src_addr_o
//   wr_addr_o     framebuffer write address
//   wr_data_o     framebuffer write data
//   wr_en_o       framebuffer write strobe
//   busy_o        pass in progress
//   done_o        one-cycle pass-complete pulse
//   all_black_o   last fade pass wrote only zero pixels

module fb_fade_engine #(
    parameter int unsigned FB_W = 240,
    parameter int unsigned FB_H = 160,
    parameter int unsigned CW   = 8,
    parameter int unsigned AW   = 19,
    parameter int unsigned STEP = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      mode_i,
    input  logic [3*CW-1:0] fill_color_i,
    input  logic            blank_i,
    output logic [AW-1:0]   rd_addr_o,
    input  logic [3*CW-1:0] rd_data_i,
    output logic [AW-1:0]   src_addr_o,
    input  logic [3*CW-1:0] src_data_i,
    output logic [AW-1:0]   wr_addr_o,
    output logic [3*CW-1:0] wr_data_o,
    output logic            wr_en_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            all_black_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FB_W * FB_H - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] M_FILL = 2'd0;
    localparam logic [1:0] M_FADE = 2'd1;
    localparam logic [1:0] M_COPY = 2'd2;
    localparam logic [1:0] M_NOP  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            iss_q, iss_d;
    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [1:0]      mode_q, mode_d;
    logic [3*CW-1:0] fill_q, fill_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            acc_q, acc_d;
    logic            all_black_q, all_black_d;
    logic            wr_nonzero;

    // Per-channel saturating subtract; channels never borrow from each other.
    function automatic logic [3*CW-1:0] fade(input logic [3*CW-1:0] px);
        logic [3*CW-1:0] res;
        logic [CW-1:0]   ch;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            ch = px[i*CW +: CW];
            res[i*CW +: CW] = (ch < CW'(STEP)) ? '0 : ch - CW'(STEP);
        end
        return res;
    endfunction

    // Write data is formed in the write cycle itself, when the RAM data for
    // the address presented one cycle earlier is on the input.
    always_comb begin
        wr_data_o = '0;
        if (wr_en_q) begin
            case (mode_q)
                M_FILL:  wr_data_o = fill_q;
                M_FADE:  wr_data_o = fade(rd_data_i);
                M_COPY:  wr_data_o = src_data_i;
                default: wr_data_o = '0;
            endcase
        end
    end

    assign wr_nonzero = wr_en_q && (wr_data_o != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        iss_d       = 1'b0;
        mode_d      = mode_q;
        fill_d      = fill_q;
        done_d      = 1'b0;
        acc_d       = acc_q && !wr_nonzero;
        all_black_d = all_black_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d      = mode_i;
                    fill_d      = fill_color_i;
                    cnt_d       = '0;
                    acc_d       = 1'b1;
                    all_black_d = 1'b0;
                    state_d     = (mode_i == M_NOP) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (blank_i) begin
                    addr_d = cnt_q;
                    iss_d  = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            default: begin
                // The final write is visible during DONE, so fold it in here.
                done_d      = 1'b1;
                all_black_d = (mode_q == M_FADE) && acc_q && !wr_nonzero;
                state_d     = S_IDLE;
            end
        endcase

        // Busy also covers the cycle in which the registered done pulse shows.
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            iss_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            mode_q      <= M_FILL;
            fill_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_q       <= 1'b0;
            all_black_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            iss_q       <= iss_d;
            wr_en_q     <= iss_q;
            wr_addr_q   <= addr_q;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            all_black_q <= all_black_d;
        end
    end

    assign rd_addr_o   = addr_q;
    assign src_addr_o  = addr_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_en_o     = wr_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign all_black_o = all_black_q;

endmodule

// File: tb/tb_fb_fade_engine.sv
// tb/tb_fb_fade_engine.sv - scoreboard bench for fb_fade_engine (4x2 framebuffer)

module tb_fb_fade_engine;

    localparam int CW  = 8;
    localparam int AW  = 19;
    localparam int NPX = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [23:0]   fill = 24'h0;
    logic          blank = 1'b1;
    logic [AW-1:0] rd_addr, src_addr, wr_addr;
    logic [23:0]   rd_data = 24'h0;
    logic [23:0]   src_data = 24'h0;
    logic [23:0]   wr_data;
    logic          wr_en, busy, done, all_black;

    fb_fade_engine #(.FB_W(4), .FB_H(2), .CW(CW), .AW(AW), .STEP(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
        .fill_color_i(fill), .blank_i(blank), .rd_addr_o(rd_addr),
        .rd_data_i(rd_data), .src_addr_o(src_addr), .src_data_i(src_data),
        .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_en_o(wr_en),
        .busy_o(busy), .done_o(done), .all_black_o(all_black)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models: data valid the cycle after the address.
    logic [23:0] fb_mem [NPX];
    logic [23:0] src_mem [NPX];
    always @(posedge clk) begin
        rd_data  <= fb_mem[rd_addr[2:0]];
        src_data <= src_mem[src_addr[2:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] exp_a[$];
    logic [23:0]   exp_d[$];
    int done_count = 0;
    int done_cyc = 0;
    int busy_cnt = 0;
    int n_writes = 0;
    int first_wr = 0;
    int last_wr = 0;
    int start_cyc = 0;
    int done_base = 0;
    bit tog = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        if (wr_en) begin
            if (n_writes == 0) first_wr = cyc;
            last_wr = cyc;
            n_writes++;
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
            end else begin
                check("wr_addr", 64'(wr_addr), 64'(exp_a.pop_front()));
                check("wr_data", 64'(wr_data), 64'(exp_d.pop_front()));
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    // Blank driver: held high, or toggling 1,0,1,0 when tog is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) blank = ~blank;
            else blank = 1'b1;
        end
    end

    task automatic push(input int a, input logic [23:0] d);
        exp_a.push_back(AW'(a));
        exp_d.push_back(d);
    endtask

    task automatic start_pass(input logic [1:0] m, input logic [23:0] fc);
        @(posedge clk);
        #1;
        done_base = done_count;
        busy_cnt  = 0;
        n_writes  = 0;
        mode  = m;
        fill  = fc;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done_count == done_base && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (done_count == done_base) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", name);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [23:0] mix_in  [NPX];
    logic [23:0] mix_out [NPX];

    initial begin
        mix_in  = '{24'h050505, 24'h060504, 24'h0A0B0C, 24'hFFFFFF,
                    24'h000000, 24'h050000, 24'h000006, 24'h808080};
        mix_out = '{24'h000000, 24'h010000, 24'h050607, 24'hFAFAFA,
                    24'h000000, 24'h000000, 24'h000001, 24'h7B7B7B};
        for (int i = 0; i < NPX; i++) begin
            fb_mem[i]  = 24'h0;
            src_mem[i] = 24'hA00000 + 24'(i * 24'h000111);
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_all_black", 64'(all_black), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        rst_n = 1'b1;

        // Mode 0 fill
        for (int i = 0; i < NPX; i++) push(i, 24'h123456);
        start_pass(2'd0, 24'h123456);
        wait_done("fill");
        check("fill_latency", 64'(done_cyc - start_cyc), 64'd11);
        check("fill_writes", 64'(n_writes), 64'd8);
        check("fill_consecutive", 64'(last_wr - first_wr), 64'd7);
        check("fill_busy_cycles", 64'(busy_cnt), 64'd11);
        check("fill_done_count", 64'(done_count - done_base), 64'd1);
        check("fill_all_black", 64'(all_black), 64'd0);
        check("fill_sb_left", 64'(exp_a.size()), 64'd0);

        // Mode 1 fade, nonzero result
        for (int i = 0; i < NPX; i++) begin fb_mem[i] = 24'h04FF06; push(i, 24'h00FA01); end
        start_pass(2'd1, 24'h0);
        wait_done("fade_a");
        check("fade_a_all_black", 64'(all_black), 64'd0);
        check("fade_a_writes", 64'(n_writes), 64'd8);

        // Mode 1 fade, boundary values per channel
        for (int i = 0; i < NPX; i++) begin fb_mem[i] = mix_in[i]; push(i, mix_out[i]); end
        start_pass(2'd1, 24'h0);
        wait_done("fade_mix");
        check("fade_mix_all_black", 64'(all_black), 64'd0);

        // Mode 1 fade, all to black
        for (int i = 0; i < NPX; i++) begin fb_mem[i] = 24'h030201; push(i, 24'h000000); end
        start_pass(2'd1, 24'h0);
        wait_done("fade_b");
        check("fade_b_all_black", 64'(all_black), 64'd1);

        // Mode 3 no-op clears all_black
        start_pass(2'd3, 24'h0);
        check("nop_all_black_cleared", 64'(all_black), 64'd0);
        wait_done("nop");
        check("nop_latency", 64'(done_cyc - start_cyc), 64'd2);
        check("nop_busy_cycles", 64'(busy_cnt), 64'd2);
        check("nop_writes", 64'(n_writes), 64'd0);
        check("nop_all_black", 64'(all_black), 64'd0);

        // Mode 2 copy with blank toggling
        for (int i = 0; i < NPX; i++) push(i, src_mem[i]);
        tog = 1'b1;
        start_pass(2'd2, 24'h0);
        wait_done("copy");
        tog = 1'b0;
        check("copy_writes", 64'(n_writes), 64'd8);
        check("copy_sb_left", 64'(exp_a.size()), 64'd0);
        check("copy_stretched", 64'(done_cyc - start_cyc > 11), 64'd1);

        // start during RUN with another mode is ignored
        for (int i = 0; i < NPX; i++) push(i, 24'hABCDEF);
        start_pass(2'd0, 24'hABCDEF);
        repeat (2) @(posedge clk);
        #1;
        mode = 2'd1;
        fill = 24'h555555;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore");
        repeat (15) @(posedge clk);
        #1;
        check("ignore_single_done", 64'(done_count - done_base), 64'd1);
        check("ignore_writes", 64'(n_writes), 64'd8);
        check("ignore_busy_idle", 64'(busy), 64'd0);

        // Reset mid-pass once address 3 is on the bus
        push(0, 24'h111111);
        push(1, 24'h111111);
        start_pass(2'd0, 24'h111111);
        for (int k = 0; k < 50 && rd_addr != AW'(3); k++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_addr3_seen", 64'(rd_addr), 64'd3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en", 64'(wr_en), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_rd_addr", 64'(rd_addr), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid_no_done", 64'(done_count - done_base), 64'd0);
        check("rst_mid_writes", 64'(n_writes), 64'd2);
        check("rst_mid_sb_left", 64'(exp_a.size()), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NPX; i++) push(i, 24'h222222);
        start_pass(2'd0, 24'h222222);
        wait_done("rst_restart");
        check("restart_writes", 64'(n_writes), 64'd8);
        check("restart_latency", 64'(done_cyc - start_cyc), 64'd11);
        check("restart_sb_left", 64'(exp_a.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
